// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store stage: alignment check, lane steering,
// strobes, load extension and a req/ack memory handshake with timeout.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [4:0]        rsp_rd,
  output logic [1:0]        rsp_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    RESP     = 2'd2
  } state_t;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_ALIGN    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  state_t      state;
  state_t      state_next;

  logic        accept;
  logic        f3_illegal;
  logic        misaligned;
  logic        tmo_hit;
  logic [1:0]  req_err;
  logic [3:0]  req_strb;
  logic [31:0] req_wrep;
  logic [31:0] shifted;
  logic [31:0] load_data;
  logic [31:0] tmo_cnt;

  logic        lat_we;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_off;
  logic [4:0]  lat_rd;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  // The timeout fires on the last permitted wait cycle so mem_req stays up exactly TIMEOUT_CYCLES cycles.
  assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_comb begin
    f3_illegal = 1'b1;
    misaligned = 1'b0;
    req_strb   = 4'b0000;
    req_wrep   = 32'h0;
    case (req_funct3)
      3'b000: begin
        f3_illegal = 1'b0;
        req_strb   = 4'b0001 << req_addr[1:0];
        req_wrep   = {4{req_wdata[7:0]}};
      end
      3'b001: begin
        f3_illegal = 1'b0;
        misaligned = req_addr[0];
        req_strb   = 4'b0011 << req_addr[1:0];
        req_wrep   = {2{req_wdata[15:0]}};
      end
      3'b010: begin
        f3_illegal = 1'b0;
        misaligned = |req_addr[1:0];
        req_strb   = 4'b1111;
        req_wrep   = req_wdata;
      end
      3'b100, 3'b101: begin
        f3_illegal = req_we;
        misaligned = req_funct3[0] & req_addr[0];
      end
      default: ;
    endcase

    if (f3_illegal) begin
      req_err = ERR_ILLEGAL;
    end else if (misaligned) begin
      req_err = ERR_ALIGN;
    end else begin
      req_err = ERR_OK;
    end
  end

  always_comb begin
    shifted = mem_rdata >> {lat_off, 3'b000};
    case (lat_funct3)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_data = mem_rdata;
      3'b100:  load_data = {24'h0, shifted[7:0]};
      3'b101:  load_data = {16'h0, shifted[15:0]};
      default: load_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = (req_err == ERR_OK) ? WAIT_MEM : RESP;
        end
      end
      WAIT_MEM: begin
        if (mem_ack || tmo_hit) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt    <= 32'h0;
      lat_we     <= 1'b0;
      lat_funct3 <= 3'b000;
      lat_off    <= 2'b00;
      lat_rd     <= 5'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'h0;
      mem_wstrb  <= 4'b0000;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 32'h0;
      rsp_rd     <= 5'd0;
      rsp_err    <= ERR_OK;
    end else begin
      // Response outputs are a single-cycle pulse and read as zero otherwise.
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_rd    <= 5'd0;
      rsp_err   <= ERR_OK;

      case (state)
        IDLE: begin
          tmo_cnt <= 32'h0;
          if (accept) begin
            lat_we     <= req_we;
            lat_funct3 <= req_funct3;
            lat_off    <= req_addr[1:0];
            lat_rd     <= req_rd;
            if (req_err == ERR_OK) begin
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_wdata <= req_we ? req_wrep : 32'h0;
              mem_wstrb <= req_we ? req_strb : 4'b0000;
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= req_err;
              rsp_rd    <= req_we ? 5'd0 : req_rd;
            end
          end
        end
        WAIT_MEM: begin
          if (mem_ack || tmo_hit) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
            mem_wstrb <= 4'b0000;
            rsp_valid <= 1'b1;
            rsp_rd    <= lat_we ? 5'd0 : lat_rd;
            // An ack on the timeout cycle still completes the access normally.
            if (mem_ack) begin
              rsp_rdata <= lat_we ? 32'h0 : load_data;
              rsp_err   <= ERR_OK;
            end else begin
              rsp_err   <= ERR_TIMEOUT;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed vector table plus multi-cycle sequences for load_store_unit.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic [31:0] mem_rdata;
  logic        auto_a;
  logic        man_a;
  logic        man_b;
  logic        ack_a;
  logic        ack_b;

  logic        req_ready_a, mem_req_a, mem_we_a, rsp_valid_a;
  logic [31:0] mem_addr_a, mem_wdata_a, rsp_rdata_a;
  logic [3:0]  mem_wstrb_a;
  logic [4:0]  rsp_rd_a;
  logic [1:0]  rsp_err_a;

  logic        req_ready_b, mem_req_b, mem_we_b, rsp_valid_b;
  logic [31:0] mem_addr_b, mem_wdata_b, rsp_rdata_b;
  logic [3:0]  mem_wstrb_b;
  logic [4:0]  rsp_rd_b;
  logic [1:0]  rsp_err_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ack_a = auto_a ? mem_req_a : man_a;
  assign ack_b = man_b;

  load_store_unit #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready_a), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_wstrb(mem_wstrb_a), .mem_ack(ack_a), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .rsp_rd(rsp_rd_a), .rsp_err(rsp_err_a)
  );

  load_store_unit dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready_b), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_wstrb(mem_wstrb_b), .mem_ack(ack_b), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_rd(rsp_rd_b), .rsp_err(rsp_err_b)
  );

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        exp_mem;
    logic [31:0] exp_maddr;
    logic [31:0] exp_mwdata;
    logic [3:0]  exp_strb;
    logic [31:0] exp_rdata;
    logic [4:0]  exp_rd;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_a) bound_fail("wait_idle");
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd);
    @(posedge clk);
    #1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_rd     = rd;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    wait_idle();
    issue(v.we, v.f3, v.addr, v.wdata, v.rd);
    @(negedge clk);
    if (v.exp_mem) begin
      chk({t, "_mem_req"}, {31'h0, mem_req_a}, 32'd1);
      chk({t, "_mem_we"}, {31'h0, mem_we_a}, {31'h0, v.we});
      chk({t, "_mem_addr"}, mem_addr_a, v.exp_maddr);
      chk({t, "_mem_wstrb"}, {28'h0, mem_wstrb_a}, {28'h0, v.exp_strb});
      if (v.we) chk({t, "_mem_wdata"}, mem_wdata_a, v.exp_mwdata);
      chk({t, "_rsp_early"}, {31'h0, rsp_valid_a}, 32'd0);
      @(negedge clk);
    end else begin
      chk({t, "_no_mem_req"}, {31'h0, mem_req_a}, 32'd0);
    end
    chk({t, "_rsp_valid"}, {31'h0, rsp_valid_a}, 32'd1);
    chk({t, "_rsp_rdata"}, rsp_rdata_a, v.exp_rdata);
    chk({t, "_rsp_rd"}, {27'h0, rsp_rd_a}, {27'h0, v.exp_rd});
    chk({t, "_rsp_err"}, {30'h0, rsp_err_a}, {30'h0, v.exp_err});
    @(negedge clk);
    chk({t, "_rsp_drop"}, {31'h0, rsp_valid_a}, 32'd0);
    chk({t, "_ready"}, {31'h0, req_ready_a}, 32'd1);
    chk({t, "_mem_drop"}, {31'h0, mem_req_a}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int pulses;
    logic got;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    mem_rdata = 32'hABCDEF11; auto_a = 1'b1; man_a = 1'b0; man_b = 1'b0;

    //        we    f3      addr         wdata         rd  mem   maddr        mwdata        strb     rdata         rd  err
    vecs[0]  = '{1'b0, 3'b010, 32'h0000000C, 32'h0,        5'd18, 1'b1, 32'h0000000C, 32'h0,        4'b0000, 32'hABCDEF11, 5'd18, 2'b00};
    vecs[1]  = '{1'b0, 3'b000, 32'h0000000F, 32'h0,        5'd5,  1'b1, 32'h0000000C, 32'h0,        4'b0000, 32'hFFFFFFAB, 5'd5,  2'b00};
    vecs[2]  = '{1'b0, 3'b100, 32'h0000000D, 32'h0,        5'd6,  1'b1, 32'h0000000C, 32'h0,        4'b0000, 32'h000000EF, 5'd6,  2'b00};
    vecs[3]  = '{1'b0, 3'b001, 32'h0000000C, 32'h0,        5'd7,  1'b1, 32'h0000000C, 32'h0,        4'b0000, 32'hFFFFEF11, 5'd7,  2'b00};
    vecs[4]  = '{1'b0, 3'b101, 32'h0000000E, 32'h0,        5'd8,  1'b1, 32'h0000000C, 32'h0,        4'b0000, 32'h0000ABCD, 5'd8,  2'b00};
    vecs[5]  = '{1'b1, 3'b000, 32'h00000011, 32'h12345678, 5'd9,  1'b1, 32'h00000010, 32'h78787878, 4'b0010, 32'h0,        5'd0,  2'b00};
    vecs[6]  = '{1'b1, 3'b001, 32'h00000012, 32'h12345678, 5'd9,  1'b1, 32'h00000010, 32'h56785678, 4'b1100, 32'h0,        5'd0,  2'b00};
    vecs[7]  = '{1'b1, 3'b010, 32'h00000010, 32'h12345678, 5'd9,  1'b1, 32'h00000010, 32'h12345678, 4'b1111, 32'h0,        5'd0,  2'b00};
    vecs[8]  = '{1'b0, 3'b010, 32'h0000000E, 32'h0,        5'd3,  1'b0, 32'h0,        32'h0,        4'b0000, 32'h0,        5'd3,  2'b01};
    vecs[9]  = '{1'b1, 3'b001, 32'h00000003, 32'h12345678, 5'd9,  1'b0, 32'h0,        32'h0,        4'b0000, 32'h0,        5'd0,  2'b01};
    vecs[10] = '{1'b0, 3'b011, 32'h00000010, 32'h0,        5'd4,  1'b0, 32'h0,        32'h0,        4'b0000, 32'h0,        5'd4,  2'b11};
    vecs[11] = '{1'b1, 3'b100, 32'h00000010, 32'h12345678, 5'd9,  1'b0, 32'h0,        32'h0,        4'b0000, 32'h0,        5'd0,  2'b11};
    vecs[12] = '{1'b0, 3'b001, 32'h0000000D, 32'h0,        5'd2,  1'b0, 32'h0,        32'h0,        4'b0000, 32'h0,        5'd2,  2'b01};

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", {31'h0, req_ready_a}, 32'd1);
    chk("reset_mem_req", {31'h0, mem_req_a}, 32'd0);
    chk("reset_mem_addr", mem_addr_a, 32'h0);
    chk("reset_mem_wstrb", {28'h0, mem_wstrb_a}, 32'h0);
    chk("reset_rsp_valid", {31'h0, rsp_valid_a}, 32'd0);
    chk("reset_rsp_err", {30'h0, rsp_err_a}, 32'h0);

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Timeout with no ack at all
    auto_a = 1'b0;
    wait_idle();
    issue(1'b0, 3'b010, 32'h00000020, 32'h0, 5'd1);
    n = 0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (rsp_valid_a) got = 1'b1;
      else if (mem_req_a) n++;
    end
    if (!got) begin
      bound_fail("tmo_rsp");
    end else begin
      chk("tmo_err", {30'h0, rsp_err_a}, 32'd2);
      chk("tmo_rdata", rsp_rdata_a, 32'h0);
      chk("tmo_mem_dropped", {31'h0, mem_req_a}, 32'd0);
    end
    chk("tmo_req_cycles", n, 32'd4);
    @(negedge clk);
    chk("tmo_ready_after", {31'h0, req_ready_a}, 32'd1);

    // Ack on the final permitted wait cycle beats the timeout
    wait_idle();
    issue(1'b0, 3'b010, 32'h0000000C, 32'h0, 5'd2);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("late_ack_wait%0d", c), {31'h0, mem_req_a}, 32'd1);
    end
    @(negedge clk);
    chk("late_ack_req4", {31'h0, mem_req_a}, 32'd1);
    man_a = 1'b1;
    @(posedge clk);
    #1;
    man_a = 1'b0;
    @(negedge clk);
    chk("late_ack_valid", {31'h0, rsp_valid_a}, 32'd1);
    chk("late_ack_err", {30'h0, rsp_err_a}, 32'd0);
    chk("late_ack_rdata", rsp_rdata_a, 32'hABCDEF11);
    chk("late_ack_rd", {27'h0, rsp_rd_a}, 32'd2);

    // Latency 5 with req_valid held high on the default-timeout instance
    do_reset();
    @(posedge clk);
    #1;
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000000C; req_rd = 5'd10;
    req_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("lat5_mem_req%0d", c), {31'h0, mem_req_b}, 32'd1);
      chk($sformatf("lat5_mem_addr%0d", c), mem_addr_b, 32'h0000000C);
      chk($sformatf("lat5_mem_we%0d", c), {31'h0, mem_we_b}, 32'd0);
      chk($sformatf("lat5_mem_wstrb%0d", c), {28'h0, mem_wstrb_b}, 32'd0);
      chk($sformatf("lat5_ready%0d", c), {31'h0, req_ready_b}, 32'd0);
      chk($sformatf("lat5_rsp%0d", c), {31'h0, rsp_valid_b}, 32'd0);
      if (c == 5) man_b = 1'b1;
    end
    @(posedge clk);
    #1;
    man_b = 1'b0;
    @(negedge clk);
    chk("lat5_rsp_valid", {31'h0, rsp_valid_b}, 32'd1);
    chk("lat5_rsp_rdata", rsp_rdata_b, 32'hABCDEF11);
    chk("lat5_rsp_rd", {27'h0, rsp_rd_b}, 32'd10);
    chk("lat5_ready_in_resp", {31'h0, req_ready_b}, 32'd0);
    chk("lat5_mem_dropped", {31'h0, mem_req_b}, 32'd0);
    @(negedge clk);
    chk("lat5_ready_after", {31'h0, req_ready_b}, 32'd1);
    chk("lat5_rsp_pulse", {31'h0, rsp_valid_b}, 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("lat5_second_req", {31'h0, mem_req_b}, 32'd1);
    man_b = 1'b1;
    @(posedge clk);
    #1;
    man_b = 1'b0;
    @(negedge clk);
    chk("lat5_second_rsp", {31'h0, rsp_valid_b}, 32'd1);

    // Reset during WAIT_MEM aborts the access
    do_reset();
    auto_a = 1'b0;
    wait_idle();
    issue(1'b0, 3'b010, 32'h0000000C, 32'h0, 5'd11);
    @(negedge clk);
    chk("rst_pre_mem_req", {31'h0, mem_req_a}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_req", {31'h0, mem_req_a}, 32'd0);
    chk("rst_rsp_valid", {31'h0, rsp_valid_a}, 32'd0);
    chk("rst_ready", {31'h0, req_ready_a}, 32'd1);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid_a || mem_req_a) pulses++;
    end
    chk("rst_no_rsp", pulses, 32'd0);

    // Stray ack while idle
    @(negedge clk);
    man_a = 1'b1;
    @(negedge clk);
    man_a = 1'b0;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid_a || mem_req_a) pulses++;
    end
    chk("stray_ack_ignored", pulses, 32'd0);
    chk("stray_ack_ready", {31'h0, req_ready_a}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
